// File: rtl/pellet_pkg.sv
// Purpose : shared constants, tile codes, FSM state type and score helper
//           for the pellet controller.
// Latency : n/a (package only).
// Backpressure : n/a.
package pellet_pkg;

  localparam int TILE_W  = 9;
  localparam int ADDR_W  = 10;
  localparam int SCORE_W = 16;

  localparam logic [TILE_W-1:0] EMPTY_CODE  = 9'h000;
  localparam logic [TILE_W-1:0] PELLET_CODE = 9'h063;
  localparam logic [TILE_W-1:0] POWER_CODE  = 9'h062;

  localparam int PELLET_PTS = 10;
  localparam int POWER_PTS  = 50;

  localparam int DEF_PELLET_TOTAL = 244;
  localparam int DEF_POWER_FRAMES = 360;
  localparam int DEF_WARN_FRAMES  = 120;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CHK  = 2'd2,
    ST_WR   = 2'd3
  } state_e;

  // Score add with one guard bit; a carry out clamps to all-ones.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  function automatic logic is_edible(input logic [TILE_W-1:0] code);
    return (code == PELLET_CODE) || (code == POWER_CODE);
  endfunction

endpackage

// File: rtl/power_timer.sv
// Purpose : frightened-mode frame counter; load, decrement on tick, clear.
// Latency : load/tick visible on active_o/warn_o the cycle after.
// Backpressure : none; clear beats load, load beats tick.
// Ports   : clk_i, rst_n_i (sync, active-low), clear_i, load_i, tick_i,
//           active_o (count != 0), warn_o (active and count <= WARN).
module power_timer #(
  parameter int FRAMES = 360,
  parameter int WARN   = 120
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic load_i,
  input  logic tick_i,
  output logic active_o,
  output logic warn_o
);

  localparam int CNT_W = $clog2(FRAMES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      // A re-hit restarts the full duration rather than extending it.
      cnt_d = CNT_W'(FRAMES);
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active_o = (cnt_q != '0);
  assign warn_o   = active_o && (cnt_q <= CNT_W'(WARN));

endmodule

// File: rtl/pellet_controller.sv
// Purpose : read-modify-write of maze tiles on tile entry; clears eaten
//           pellets, keeps score, pellets-left, level-clear and power timer.
// Latency : tile_valid at N -> ram_we at N+3; busy N+1..N+3.
// Backpressure : none upstream; requests arriving while busy go to a
//           1-entry holding slot, newest request overwrites the slot.
// Ports   : Clk/Reset_n; tile_valid/tile_addr request; frame_tick,
//           level_reset; BRAM port A (ram_addr, ram_rd_data, ram_we,
//           ram_wr_data); status busy, score, pellet_eaten, power_start,
//           power_active, power_warn, pellets_left, level_clear.
module pellet_controller
  import pellet_pkg::*;
#(
  parameter int PELLET_TOTAL = DEF_PELLET_TOTAL,
  parameter int POWER_FRAMES = DEF_POWER_FRAMES,
  parameter int WARN_FRAMES  = DEF_WARN_FRAMES
) (
  input  logic                              Clk,
  input  logic                              Reset_n,
  input  logic                              tile_valid,
  input  logic [ADDR_W-1:0]                 tile_addr,
  input  logic                              frame_tick,
  input  logic                              level_reset,
  output logic [ADDR_W-1:0]                 ram_addr,
  input  logic [TILE_W-1:0]                 ram_rd_data,
  output logic                              ram_we,
  output logic [TILE_W-1:0]                 ram_wr_data,
  output logic                              busy,
  output logic [SCORE_W-1:0]                score,
  output logic                              pellet_eaten,
  output logic                              power_start,
  output logic                              power_active,
  output logic                              power_warn,
  output logic [$clog2(PELLET_TOTAL+1)-1:0] pellets_left,
  output logic                              level_clear
);

  localparam int LEFT_W = $clog2(PELLET_TOTAL + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                slot_vld_q, slot_vld_d;
  logic [ADDR_W-1:0]   slot_addr_q, slot_addr_d;
  logic                is_power_q, is_power_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [LEFT_W-1:0]   left_q, left_d;
  logic                clear_q, clear_d;
  logic                wr_go;

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (slot_vld_q || tile_valid) state_d = ST_RD;
      ST_RD:   state_d = ST_CHK;
      ST_CHK:  state_d = is_edible(ram_rd_data) ? ST_WR : ST_IDLE;
      ST_WR:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (level_reset) state_d = ST_IDLE;
  end

  // Output logic. The write and its pulses are gated by reset and
  // level_reset so an aborted WR cycle never reaches the RAM.
  always_comb begin
    wr_go        = (state_q == ST_WR) && Reset_n && !level_reset;
    ram_we       = wr_go;
    pellet_eaten = wr_go && !is_power_q;
    power_start  = wr_go && is_power_q;
    busy         = (state_q != ST_IDLE);
  end

  // Request address and holding slot. A pending slot is always served
  // before a fresh request; the fresh one then takes the slot.
  always_comb begin
    addr_d      = addr_q;
    slot_vld_d  = slot_vld_q;
    slot_addr_d = slot_addr_q;
    if (state_q == ST_IDLE) begin
      if (slot_vld_q) begin
        addr_d     = slot_addr_q;
        slot_vld_d = tile_valid;
        if (tile_valid) slot_addr_d = tile_addr;
      end else if (tile_valid) begin
        addr_d = tile_addr;
      end
    end else if (tile_valid) begin
      slot_vld_d  = 1'b1;
      slot_addr_d = tile_addr;
    end
    if (level_reset) slot_vld_d = 1'b0;
  end

  assign is_power_d = (state_q == ST_CHK) ? (ram_rd_data == POWER_CODE) : is_power_q;

  // Score and pellet bookkeeping
  always_comb begin
    score_d = score_q;
    left_d  = left_q;
    clear_d = clear_q;
    if (level_reset) begin
      left_d  = LEFT_W'(PELLET_TOTAL);
      clear_d = 1'b0;
    end else if (wr_go) begin
      score_d = sat_add(score_q, is_power_q ? SCORE_W'(POWER_PTS) : SCORE_W'(PELLET_PTS));
      // Held at zero so a maze with extra pellets cannot wrap the count.
      if (left_q != '0) begin
        left_d = left_q - LEFT_W'(1);
        if (left_q == LEFT_W'(1)) clear_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      addr_q      <= '0;
      slot_vld_q  <= 1'b0;
      slot_addr_q <= '0;
      is_power_q  <= 1'b0;
      score_q     <= '0;
      left_q      <= LEFT_W'(PELLET_TOTAL);
      clear_q     <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      slot_vld_q  <= slot_vld_d;
      slot_addr_q <= slot_addr_d;
      is_power_q  <= is_power_d;
      score_q     <= score_d;
      left_q      <= left_d;
      clear_q     <= clear_d;
    end
  end

  power_timer #(
    .FRAMES (POWER_FRAMES),
    .WARN   (WARN_FRAMES)
  ) u_power_timer (
    .clk_i    (Clk),
    .rst_n_i  (Reset_n),
    .clear_i  (level_reset),
    .load_i   (power_start),
    .tick_i   (frame_tick),
    .active_o (power_active),
    .warn_o   (power_warn)
  );

  assign ram_addr     = addr_q;
  assign ram_wr_data  = EMPTY_CODE;
  assign score        = score_q;
  assign pellets_left = left_q;
  assign level_clear  = clear_q;

endmodule
